deco_exe_stage_reg: RTL

- Pipeline boundary between instruction decode and execute.
- Registers the decoded control bundle (deco_exe_cu_signals), operand values, immediate and register addresses into the EXE stage.
- Detects load-use hazards, inserts bubbles on load-use and flush, and generates stall requests for fetch and decode.
- Keeps two saturating performance counters (bubbles, flushes).

---
 rtl/stages_definition_pkg.sv | 21 ++
 rtl/hazard_detect.sv | 40 ++++
 rtl/deco_exe_stage_reg.sv | 100 ++++++++++
 3 files changed

// File: rtl/stages_definition_pkg.sv
// Shared decode/execute types: control bundle, NOP bundle, memToReg codes.
// Imported by the decode/execute boundary register and its hazard logic.
package stages_definition_pkg;

    typedef struct packed {
        logic       regWrite;
        logic       memWrite;
        logic       memPixWrite;
        logic       branch;
        logic       flagWrite;
        logic       pcSrc;
        logic       trigControl;
        logic [3:0] aluControl;
        logic [1:0] memToReg;
    } deco_exe_cu_signals;

    localparam deco_exe_cu_signals NOP_CTRL = '0;

    localparam logic [1:0] MEM_TO_REG_ALU = 2'b01;

endpackage

// File: rtl/hazard_detect.sv
// Combinational load-use detection and fetch/decode stall generation.
// Ports: EXE regWrite/memToReg/valid/wa, decode sources, stall/flush -> stalls.
module hazard_detect
    import stages_definition_pkg::*;
#(
    parameter int REG_ADDR_W = 4
) (
    input  logic                  exeValid,
    input  logic                  exeRegWrite,
    input  logic [1:0]            exeMemToReg,
    input  logic [REG_ADDR_W-1:0] exeWa,
    input  logic                  decoValid,
    input  logic [REG_ADDR_W-1:0] decoRa1,
    input  logic [REG_ADDR_W-1:0] decoRa2,
    input  logic                  decoUse1,
    input  logic                  decoUse2,
    input  logic                  stall,
    input  logic                  flush,
    output logic                  loadUse,
    output logic                  stallFetch,
    output logic                  stallDeco
);

    logic lateResult;
    logic srcHit;

    // Anything not written back from the ALU arrives too late to forward.
    assign lateResult = exeValid && exeRegWrite &&
                        (exeMemToReg != MEM_TO_REG_ALU);

    assign srcHit = (decoUse1 && (decoRa1 == exeWa)) ||
                    (decoUse2 && (decoRa2 == exeWa));

    assign loadUse = lateResult && decoValid && srcHit;

    // A flush squashes the dependent instruction, so no hold is needed.
    assign stallFetch = (stall || loadUse) && !flush;
    assign stallDeco  = stallFetch;

endmodule

// File: rtl/deco_exe_stage_reg.sv
// Decode -> execute pipeline register with bubble insertion and perf counters.
// Ports: deco_* bundle in, exe_* bundle out, stall_fetch/deco, bubble/flush cnt.
module deco_exe_stage_reg
    import stages_definition_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 4,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  stall_i,
    input  logic                  flush_i,
    input  logic                  deco_valid_i,
    input  deco_exe_cu_signals    deco_ctrl_i,
    input  logic [DATA_W-1:0]     deco_rd1_i,
    input  logic [DATA_W-1:0]     deco_rd2_i,
    input  logic [DATA_W-1:0]     deco_imm_i,
    input  logic [REG_ADDR_W-1:0] deco_ra1_i,
    input  logic [REG_ADDR_W-1:0] deco_ra2_i,
    input  logic                  deco_use1_i,
    input  logic                  deco_use2_i,
    input  logic [REG_ADDR_W-1:0] deco_wa_i,
    output logic                  exe_valid_o,
    output deco_exe_cu_signals    exe_ctrl_o,
    output logic [DATA_W-1:0]     exe_rd1_o,
    output logic [DATA_W-1:0]     exe_rd2_o,
    output logic [DATA_W-1:0]     exe_imm_o,
    output logic [REG_ADDR_W-1:0] exe_ra1_o,
    output logic [REG_ADDR_W-1:0] exe_ra2_o,
    output logic [REG_ADDR_W-1:0] exe_wa_o,
    output logic                  stall_fetch_o,
    output logic                  stall_deco_o,
    output logic [CNT_W-1:0]      bubble_cnt_o,
    output logic [CNT_W-1:0]      flush_cnt_o
);

    logic loadUse;

    hazard_detect #(
        .REG_ADDR_W(REG_ADDR_W)
    ) hazardDetect (
        .exeValid   (exe_valid_o),
        .exeRegWrite(exe_ctrl_o.regWrite),
        .exeMemToReg(exe_ctrl_o.memToReg),
        .exeWa      (exe_wa_o),
        .decoValid  (deco_valid_i),
        .decoRa1    (deco_ra1_i),
        .decoRa2    (deco_ra2_i),
        .decoUse1   (deco_use1_i),
        .decoUse2   (deco_use2_i),
        .stall      (stall_i),
        .flush      (flush_i),
        .loadUse    (loadUse),
        .stallFetch (stall_fetch_o),
        .stallDeco  (stall_deco_o)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            exe_valid_o  <= 1'b0;
            exe_ctrl_o   <= NOP_CTRL;
            exe_rd1_o    <= '0;
            exe_rd2_o    <= '0;
            exe_imm_o    <= '0;
            exe_ra1_o    <= '0;
            exe_ra2_o    <= '0;
            exe_wa_o     <= '0;
            bubble_cnt_o <= '0;
            flush_cnt_o  <= '0;
        end else if (flush_i || (!stall_i && loadUse)) begin
            exe_valid_o <= 1'b0;
            exe_ctrl_o  <= NOP_CTRL;
            exe_rd1_o   <= '0;
            exe_rd2_o   <= '0;
            exe_imm_o   <= '0;
            exe_ra1_o   <= '0;
            exe_ra2_o   <= '0;
            exe_wa_o    <= '0;
            // Flush outranks load-use: each bubble is counted once.
            if (flush_i) begin
                if (flush_cnt_o != '1)
                    flush_cnt_o <= flush_cnt_o + CNT_W'(1);
            end else begin
                if (bubble_cnt_o != '1)
                    bubble_cnt_o <= bubble_cnt_o + CNT_W'(1);
            end
        end else if (!stall_i) begin
            exe_valid_o <= deco_valid_i;
            exe_ctrl_o  <= deco_valid_i ? deco_ctrl_i : NOP_CTRL;
            exe_rd1_o   <= deco_rd1_i;
            exe_rd2_o   <= deco_rd2_i;
            exe_imm_o   <= deco_imm_i;
            exe_ra1_o   <= deco_ra1_i;
            exe_ra2_o   <= deco_ra2_i;
            exe_wa_o    <= deco_wa_i;
        end
    end

endmodule
